// File: rtl/instr_supply_unit_if.sv
// instr_supply_unit_if: load port, fetch request/response and status signals of the instruction supply unit
interface instr_supply_unit_if #(parameter int DEPTH_LOG2 = 6);
  logic                  LoadEn;
  logic [DEPTH_LOG2-1:0] LoadAddr;
  logic [31:0]           LoadData;
  logic                  Start;
  logic                  FetchReq;
  logic [31:0]           PC;
  logic                  Ready;
  logic [31:0]           Instruction;
  logic                  InstrValid;
  logic                  FetchErr;
  logic                  Halted;
  logic [15:0]           FetchCount;
  modport master (
    output LoadEn, LoadAddr, LoadData, Start, FetchReq, PC,
    input  Ready, Instruction, InstrValid, FetchErr, Halted, FetchCount
  );
  modport slave (
    input  LoadEn, LoadAddr, LoadData, Start, FetchReq, PC,
    output Ready, Instruction, InstrValid, FetchErr, Halted, FetchCount
  );
endinterface

// File: rtl/instr_supply_unit.sv
// instr_supply_unit: program store that is loaded by a host, then answers PC-addressed fetches until ebreak or a bad PC
module instr_supply_unit #(
  parameter int          DEPTH_LOG2 = 6,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013,
  parameter logic [31:0] HALT_WORD  = 32'h0010_0073
) (
  input logic               CLK,
  input logic               ResetPC,
  instr_supply_unit_if.slave bus
);
  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  logic [1:0]            state_q, state_d;
  logic [31:0]           mem_q [2**DEPTH_LOG2];
  logic [31:0]           instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           word;
  logic                  bad, fetch, stop;
  assign idx   = bus.PC[DEPTH_LOG2+1:2];
  assign word  = mem_q[idx];
  assign bad   = (|bus.PC[1:0]) || (|bus.PC[31:DEPTH_LOG2+2]);
  assign fetch = (state_q == S_RUN) && bus.FetchReq;
  assign stop  = bad || (word == HALT_WORD);
  always_comb begin
    state_d = (state_q == S_LOAD && bus.Start) ? S_RUN :
              (fetch && stop) ? S_HALT : state_q;
    instr_d = fetch ? (bad ? NOP_WORD : word) :
              (state_q == S_HALT) ? NOP_WORD : instr_q;
    valid_d = fetch;
    err_d   = err_q | (fetch & bad);
    cnt_d   = (fetch && !bad && !(&cnt_q)) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (ResetPC) begin
      state_q <= S_LOAD;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  // the whole store is cleared by reset so a reload without data reads back NOP
  always_ff @(posedge CLK) begin
    if (ResetPC) begin
      for (int i = 0; i < 2**DEPTH_LOG2; i++) mem_q[i] <= NOP_WORD;
    end else if (state_q == S_LOAD && bus.LoadEn) begin
      mem_q[bus.LoadAddr] <= bus.LoadData;
    end
  end
  assign bus.Ready       = (state_q == S_RUN);
  assign bus.Halted      = (state_q == S_HALT);
  assign bus.Instruction = instr_q;
  assign bus.InstrValid  = valid_q;
  assign bus.FetchErr    = err_q;
  assign bus.FetchCount  = cnt_q;
endmodule

// File: doc/instr_supply_unit.md
# instr_supply_unit

Instruction supply side of the single-cycle RISC-V core's fetch interface: holds a program image in a word-addressed instruction store and answers the core's PC-addressed fetch requests with 32-bit instruction words. A host or bench loads the program through a write port and then issues Start. After Start, the unit serves fetches until it returns `ebreak` or detects a bad PC, then parks in a halted state. It replaces hand-driven instruction stimulus in front of the core.

## Interface
- `DEPTH_LOG2`, 6, log2 of store depth in 32-bit words (64 words = 256 bytes of PC space).
- `NOP_WORD`, 32'h0000_0013, word returned on error and while halted (`addi x0,x0,0`).
- `HALT_WORD`, 32'h0010_0073, word that ends the run (`ebreak`).

- `CLK`  in  1  clock; all state changes on the rising edge.
- `ResetPC`  in  1  synchronous, active-high reset; priority over every other input.
- `LoadEn`  in  1  write strobe for the program store; honoured only in LOAD.
- `LoadAddr`  in  DEPTH_LOG2  word index to write.
- `LoadData`  in  32  instruction word to write.
- `Start`  in  1  leave LOAD and begin serving fetches; honoured only in LOAD.
- `FetchReq`  in  1  fetch request; accepted only when `Ready`=1.
- `PC`  in  32  byte address of the requested instruction.
- `Ready`  out  1  1 only in RUN.
- `Instruction`  out  32  registered fetch response.
- `InstrValid`  out  1  1-cycle pulse per accepted fetch.
- `FetchErr`  out  1  set with a bad-PC response; sticky until reset.
- `Halted`  out  1  1 in HALT.
- `FetchCount`  out  16  count of successful fetches; saturates at 16'hFFFF.

## Operation
- Reset values: state LOAD, `Ready`=0, `Instruction`=NOP_WORD, `InstrValid`=0, `FetchErr`=0, `Halted`=0, `FetchCount`=0. Every store word is set to NOP_WORD during the reset cycle.
- FSM states: LOAD, RUN, HALT.
  - LOAD→RUN on `Start`.
  - RUN→HALT when a response carries HALT_WORD or an error.
  - HALT→LOAD only through `ResetPC`.
- LOAD state:
  - `LoadEn`=1 writes `mem[LoadAddr]`=`LoadData`. A later write to the same address overwrites the earlier one.
  - `FetchReq` is ignored and `InstrValid` stays 0.
  - If `LoadEn` and `Start` are high in the same cycle, the write takes effect and the state moves to RUN.
- RUN state:
  - `LoadEn` and `Start` are ignored.
  - Word index is `PC[DEPTH_LOG2+1:2]`.
  - Error condition: `PC[1:0]`≠0, or any bit of `PC[31:DEPTH_LOG2+2]` is 1.
  - Accepted good fetch: `Instruction`←`mem[index]`, `InstrValid`←1, `FetchCount`+1 (saturating).
  - Accepted bad fetch: `Instruction`←NOP_WORD, `InstrValid`←1, `FetchErr`←1, next state HALT. `FetchCount` is unchanged.
  - A good fetch that returns HALT_WORD delivers the `ebreak` word with `InstrValid`=1, counts toward `FetchCount`, and sets next state to HALT.
  - No request: `InstrValid`←0 and `Instruction` holds its last value.
- HALT state:
  - `Instruction`←NOP_WORD on every edge and `InstrValid`=0.
  - `FetchReq`, `LoadEn` and `Start` are ignored.
  - `FetchErr` and `FetchCount` are frozen.

## Timing
- `Ready` and `Halted` are decoded directly from the registered state.
- `Start` sampled at edge N gives `Ready`=1 from edge N onward, so the first fetch can be presented in the following cycle.
- Fetch latency is 1 cycle: a request sampled at edge N produces `Instruction`/`InstrValid`/`FetchErr` valid in the cycle after edge N.
- Back-to-back requests are served at 1 per cycle with no bubbles.
- Halt timing: the edge that registers the `ebreak` or error response also sets HALT.
  - `Halted` rises and `Ready` falls in the same cycle as that final `InstrValid` pulse.
  - A request presented in that cycle is dropped.
  - `Instruction` becomes NOP_WORD one edge later.
- Reset mid-run: `ResetPC` sampled at any edge discards any pending fetch, clears the store and returns the unit to LOAD. `InstrValid` is 0 in the cycle after that edge.

## Test plan
- **Load then fetch:** load word 0=32'h0020_80B3 and word 1=32'h4030_8233, then Start, then fetch PC=0 and PC=4 on consecutive cycles → two consecutive `InstrValid` pulses carrying those words, `FetchCount`=2.
- **Ignored requests:** assert `FetchReq` while in LOAD, and `LoadEn` while in RUN → no `InstrValid` pulse and the store is unchanged (a later fetch of the written address returns the old word).
- **Bad PC:** fetch PC=32'h0000_0006, and separately PC=32'h0000_0100 → response `Instruction`=NOP_WORD with `InstrValid`=1 and `FetchErr`=1. `Halted`=1 in the same cycle, `FetchCount` is unchanged, and later requests are ignored.
- **Halt word:** place HALT_WORD at word 3, fetch PC=0,4,8,C back-to-back, plus one extra request after PC=C → the fourth response is 32'h0010_0073 and the extra request is dropped. `Instruction`=NOP_WORD on the next cycle and `FetchCount`=4.
- **Mid-run reset:** pulse `ResetPC` during a burst of fetches → the next cycle shows `InstrValid`=0, `Ready`=0, `FetchCount`=0, and a fetch of any word after a reload without data returns NOP_WORD.
- **Counter saturation:** force or preload `FetchCount` to 16'hFFFE, then issue 3 good fetches → `FetchCount` stays at 16'hFFFF.
